// File: rtl/rf_writeback_unit_pkg.sv
// rv32_pkg: shared constants and types for the register-file writeback path.
//   XLEN       - data width of results and register-file write data
//   REG_ADDR_W - register index width (32 architectural registers)
//   REG_ZERO   - index of the hard-wired zero register x0
//   wb_src_e   - identifies which producer owns the current write
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

endpackage

// File: rtl/rf_writeback_unit_slot.sv
// wb_slot: one-entry holding buffer for a single writeback producer.
//   clk, rst  - clock, synchronous active-high reset (empties the slot)
//   valid_i   - producer presents a result
//   ready_o   - slot accepts this cycle: empty, or being drained by a grant
//   rd_i      - destination register of the presented result
//   data_i    - presented result value
//   grant_i   - arbiter drains the slot on this edge
//   full_o    - slot holds an entry
//   rd_o      - buffered destination register
//   data_o    - buffered result value
//
// Handshake: a transfer happens on a rising edge where valid_i && ready_o.
// ready_o depends only on registered state (full and the arbiter grant, which
// is itself derived from registered state) plus reset, so no combinational
// path exists from valid_i to ready_o.
module wb_slot #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [ADDR_W-1:0] rd_i,
   input  logic [XLEN-1:0]   data_i,
   input  logic              grant_i,
   output logic              full_o,
   output logic [ADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]   data_o
);
   import rv32_pkg::*;

   logic              full_q, full_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic              accept;
   logic              fill;

   assign ready_o = !rst && (!full_q || grant_i);
   assign accept  = valid_i && ready_o;
   // Writes to x0 complete the handshake but are dropped here, so they never
   // occupy the slot or reach the register file.
   assign fill    = accept && (rd_i != ADDR_W'(REG_ZERO));

   always_comb begin
      full_d = full_q;
      rd_d   = rd_q;
      data_d = data_q;
      if (fill) begin
         full_d = 1'b1;
         rd_d   = rd_i;
         data_d = data_i;
      end else if (grant_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign rd_o   = rd_q;
   assign data_o = data_q;

endmodule

// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: collects ALU and LSU results and drives the register-file
// write port with at most one registered write per cycle.
//   clk, rst               - clock, synchronous active-high reset
//   alu_valid/alu_ready    - ALU result handshake; alu_rd, alu_result payload
//   lsu_valid/lsu_ready    - load data handshake; lsu_rd, lsu_data payload
//   write_enable           - registered register-file write strobe
//   write_addr, write_data - registered write index and value (hold when idle)
//   retire_count           - number of write_enable pulses, wraps at 2^32
//
// Handshake: each source transfers on a rising edge where valid && ready.
// ready never depends on valid in the same cycle.
//
// Arbitration: the LSU wins by default. starve_q counts consecutive LSU grants
// taken while the ALU slot was waiting; once it reaches STARVE_LIMIT with both
// slots full the ALU is forced through, which yields an LSU,...,ALU rotation
// of period STARVE_LIMIT+1 under sustained contention.
module rf_writeback_unit #(
   parameter int XLEN         = rv32_pkg::XLEN,
   parameter int ADDR_W       = rv32_pkg::REG_ADDR_W,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [XLEN-1:0]   write_data,
   output logic [31:0]       retire_count
);
   import rv32_pkg::*;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic              alu_full, lsu_full;
   logic [ADDR_W-1:0] alu_slot_rd, lsu_slot_rd;
   logic [XLEN-1:0]   alu_slot_data, lsu_slot_data;
   logic              grant_alu, grant_lsu, grant_any;
   wb_src_e           grant_src;

   logic [3:0]        starve_q, starve_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [31:0]       retire_q, retire_d;

   wb_slot #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_alu_slot (
      .clk     (clk),
      .rst     (rst),
      .valid_i (alu_valid),
      .ready_o (alu_ready),
      .rd_i    (alu_rd),
      .data_i  (alu_result),
      .grant_i (grant_alu),
      .full_o  (alu_full),
      .rd_o    (alu_slot_rd),
      .data_o  (alu_slot_data)
   );

   wb_slot #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_lsu_slot (
      .clk     (clk),
      .rst     (rst),
      .valid_i (lsu_valid),
      .ready_o (lsu_ready),
      .rd_i    (lsu_rd),
      .data_i  (lsu_data),
      .grant_i (grant_lsu),
      .full_o  (lsu_full),
      .rd_o    (lsu_slot_rd),
      .data_o  (lsu_slot_data)
   );

   // Grant is a function of registered state only.
   always_comb begin
      grant_alu = alu_full && (!lsu_full || (starve_q == LIMIT));
      grant_lsu = lsu_full && !grant_alu;
      grant_any = grant_alu || grant_lsu;
      grant_src = grant_alu ? WB_SRC_ALU : WB_SRC_LSU;
   end

   always_comb begin
      starve_d = starve_q;
      if (grant_lsu && alu_full) begin
         starve_d = starve_q + 4'd1;
      end else if (grant_alu || !alu_full) begin
         starve_d = '0;
      end
   end

   // write_addr/write_data hold their last value on idle cycles; retire
   // counts alongside write_enable so the count includes the visible write.
   always_comb begin
      we_d     = grant_any;
      addr_d   = addr_q;
      data_d   = data_q;
      retire_d = retire_q;
      if (grant_any) begin
         retire_d = retire_q + 32'd1;
         if (grant_src == WB_SRC_ALU) begin
            addr_d = alu_slot_rd;
            data_d = alu_slot_data;
         end else begin
            addr_d = lsu_slot_rd;
            data_d = lsu_slot_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         retire_q <= '0;
      end else begin
         starve_q <= starve_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         retire_q <= retire_d;
      end
   end

   assign write_enable = we_q;
   assign write_addr   = addr_q;
   assign write_data   = data_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
module tb_rf_writeback_unit;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int LIMIT  = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              alu_valid = 1'b0, lsu_valid = 1'b0;
   logic              alu_ready, lsu_ready;
   logic [ADDR_W-1:0] alu_rd = '0, lsu_rd = '0;
   logic [XLEN-1:0]   alu_result = '0, lsu_data = '0;
   logic              write_enable;
   logic [ADDR_W-1:0] write_addr;
   logic [XLEN-1:0]   write_data;
   logic [31:0]       retire_count;

   rf_writeback_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_result   (alu_result),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .retire_count (retire_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each source holds at most one pending {rd,data}; the writes leave in the
   // order dictated by LSU priority with the starvation override.
   logic [ADDR_W+XLEN-1:0] m_a[$];
   logic [ADDR_W+XLEN-1:0] m_l[$];
   int                     m_starve = 0;
   logic                   m_we = 1'b0;
   logic [ADDR_W-1:0]      m_addr = '0;
   logic [XLEN-1:0]        m_data = '0;
   logic [31:0]            m_retire = '0;
   int                     cyc = 0;

   function automatic logic m_alu_wins();
      return (m_a.size() != 0) && ((m_l.size() == 0) || (m_starve == LIMIT));
   endfunction

   function automatic logic m_lsu_wins();
      return (m_l.size() != 0) && !m_alu_wins();
   endfunction

   always @(posedge clk) begin
      logic ga, gl, ra, rl;
      cyc++;
      if (rst) begin
         m_a.delete();
         m_l.delete();
         m_starve = 0;
         m_we     = 1'b0;
         m_addr   = '0;
         m_data   = '0;
         m_retire = '0;
      end else begin
         ga = m_alu_wins();
         gl = m_lsu_wins();
         ra = (m_a.size() == 0) || ga;
         rl = (m_l.size() == 0) || gl;
         if (ga) begin
            m_we = 1'b1;
            {m_addr, m_data} = m_a.pop_front();
            m_starve = 0;
            m_retire++;
         end else if (gl) begin
            m_we = 1'b1;
            {m_addr, m_data} = m_l.pop_front();
            m_starve = (m_a.size() != 0) ? m_starve + 1 : 0;
            m_retire++;
         end else begin
            m_we = 1'b0;
            m_starve = 0;
         end
         if (alu_valid && ra && (alu_rd != '0)) m_a.push_back({alu_rd, alu_result});
         if (lsu_valid && rl && (lsu_rd != '0)) m_l.push_back({lsu_rd, lsu_data});
      end
   end

   // ---------------- compare process + write log ----------------
   logic [ADDR_W-1:0] obs_addr[$];
   logic [XLEN-1:0]   obs_data[$];
   int                obs_cyc[$];

   always @(negedge clk) begin
      logic exp_ar, exp_lr;
      exp_ar = !rst && ((m_a.size() == 0) || m_alu_wins());
      exp_lr = !rst && ((m_l.size() == 0) || m_lsu_wins());
      check("alu_ready", 64'(alu_ready), 64'(exp_ar));
      check("lsu_ready", 64'(lsu_ready), 64'(exp_lr));
      check("write_enable", 64'(write_enable), 64'(m_we));
      check("write_addr", 64'(write_addr), 64'(m_addr));
      check("write_data", 64'(write_data), 64'(m_data));
      check("retire_count", 64'(retire_count), 64'(m_retire));
      if (write_enable === 1'b1) begin
         obs_addr.push_back(write_addr);
         obs_data.push_back(write_data);
         obs_cyc.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      obs_addr.delete();
      obs_data.delete();
      obs_cyc.delete();
   endtask

   // ---------------- directed tests ----------------
   logic [ADDR_W-1:0] exp4[16] = '{5'd9, 5'd10, 5'd11, 5'd1, 5'd12, 5'd13, 5'd14, 5'd2,
                                   5'd15, 5'd16, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

   initial begin
      int ia, il;
      logic acc_a, acc_l;
      logic [31:0] r0;

      // 1: reset held with both valids high
      rst = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h1234;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h5678;
      step();
      step();
      check("rst_alu_ready", 64'(alu_ready), 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      check("rst_we", 64'(write_enable), 64'd0);
      check("rst_retire", 64'(retire_count), 64'd0);
      rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
      clear_log();
      repeat (3) step();
      check("rst_no_write", 64'(obs_addr.size()), 64'd0);

      // 2: single ALU write, two-cycle latency
      alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h0000_0008;
      step();
      alu_valid = 1'b0;
      check("alu_lat_we_early", 64'(write_enable), 64'd0);
      step();
      check("alu_we", 64'(write_enable), 64'd1);
      check("alu_addr", 64'(write_addr), 64'd5);
      check("alu_data", 64'(write_data), 64'h8);
      check("alu_retire", 64'(retire_count), 64'd1);
      step();

      // 3: x0 filter
      r0 = retire_count;
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD_BEEF;
      #1;
      check("x0_lsu_ready", 64'(lsu_ready), 64'd1);
      step();
      lsu_valid = 1'b0;
      clear_log();
      repeat (4) step();
      check("x0_no_write", 64'(obs_addr.size()), 64'd0);
      check("x0_retire", 64'(retire_count), 64'(r0));

      // 4: contention, both sources streaming
      clear_log();
      ia = 0; il = 0;
      for (int c = 0; c < 60 && (ia < 8 || il < 8); c++) begin
         alu_valid  = (ia < 8);
         alu_rd     = 5'(ia + 1);
         alu_result = 32'(ia + 1) * 32'h11;
         lsu_valid  = (il < 8);
         lsu_rd     = 5'(il + 9);
         lsu_data   = 32'(il + 9) * 32'h11;
         @(negedge clk);
         acc_a = alu_valid && alu_ready;
         acc_l = lsu_valid && lsu_ready;
         @(posedge clk);
         #2;
         if (acc_a) ia++;
         if (acc_l) il++;
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (6) step();
      check("cont_count", 64'(obs_addr.size()), 64'd16);
      if (obs_addr.size() == 16) begin
         for (int k = 0; k < 16; k++) begin
            check("cont_addr", 64'(obs_addr[k]), 64'(exp4[k]));
            check("cont_data", 64'(obs_data[k]), 64'(32'(exp4[k]) * 32'h11));
         end
         check("cont_rate", 64'(obs_cyc[15] - obs_cyc[0]), 64'd15);
      end

      // 5: same rd in both slots
      clear_log();
      alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h18;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data   = 32'h08;
      step();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (3) step();
      check("same_rd_count", 64'(obs_addr.size()), 64'd2);
      if (obs_addr.size() == 2) begin
         check("same_rd_first_addr", 64'(obs_addr[0]), 64'd2);
         check("same_rd_first_data", 64'(obs_data[0]), 64'h08);
         check("same_rd_second_addr", 64'(obs_addr[1]), 64'd2);
         check("same_rd_second_data", 64'(obs_data[1]), 64'h18);
         check("same_rd_gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
      end

      // 6: reset with both slots full
      alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data   = 32'h44;
      step();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      clear_log();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("midrst_alu_ready", 64'(alu_ready), 64'd1);
      check("midrst_lsu_ready", 64'(lsu_ready), 64'd1);
      repeat (3) step();
      check("midrst_no_write", 64'(obs_addr.size()), 64'd0);
      check("midrst_retire", 64'(retire_count), 64'd0);

      // 7: retire counter wrap
      force dut.retire_q = 32'hFFFF_FFFF;
      m_retire = 32'hFFFF_FFFF;
      #1;
      release dut.retire_q;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h1;
      step();
      alu_valid = 1'b0;
      step();
      check("wrap_we", 64'(write_enable), 64'd1);
      check("wrap_retire", 64'(retire_count), 64'd0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
